// File: rtl/yadmc_dpram_pkg.sv
// Shared constants and types for the single-port dpram arbiter.
// Holds the default geometry and the requester-id encoding.
package yadmc_dpram_pkg;

  localparam int DEFAULT_ADDRESS_DEPTH = 10;
  localparam int DEFAULT_DATA_WIDTH    = 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // One slot of the read-tracking pipeline: an accepted read and who issued it.
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, id: REQ_A};

endpackage

// File: rtl/yadmc_dpram_arb_if.sv
// Requester-side bus of the dpram arbiter: two command channels (A, B),
// their read strobes and the shared read-data bus.
interface yadmc_dpram_arb_if
  import yadmc_dpram_pkg::*;
#(
  parameter int address_depth = DEFAULT_ADDRESS_DEPTH,
  parameter int data_width    = DEFAULT_DATA_WIDTH
);

  logic                     a_valid;
  logic                     a_ready;
  logic                     a_we;
  logic [address_depth-1:0] a_adr;
  logic [data_width-1:0]    a_di;
  logic                     a_rvalid;

  logic                     b_valid;
  logic                     b_ready;
  logic                     b_we;
  logic [address_depth-1:0] b_adr;
  logic [data_width-1:0]    b_di;
  logic                     b_rvalid;

  logic [data_width-1:0]    rdata;

  modport master (
    output a_valid, a_we, a_adr, a_di,
    output b_valid, b_we, b_adr, b_di,
    input  a_ready, a_rvalid,
    input  b_ready, b_rvalid,
    input  rdata
  );

  modport slave (
    input  a_valid, a_we, a_adr, a_di,
    input  b_valid, b_we, b_adr, b_di,
    output a_ready, a_rvalid,
    output b_ready, b_rvalid,
    output rdata
  );

endinterface

// File: rtl/yadmc_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational from the valids and
// the last winner; the last winner only moves on an accepted transfer.
module yadmc_rr_arb2
  import yadmc_dpram_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic valid_a,
  input  logic valid_b,
  input  logic accept,
  output logic grant_a,
  output logic grant_b
);

  req_id_e last_grant_q;
  req_id_e last_grant_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    last_grant_d = last_grant_q;
    grant_a      = !sys_rst && valid_a && (!valid_b || last_grant_q == REQ_B);
    grant_b      = !sys_rst && valid_b && (!valid_a || last_grant_q == REQ_A);
    if (accept) begin
      last_grant_d = grant_b ? REQ_B : REQ_A;
    end
  end

  // Reset to B so that A wins the first contention.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge value of every other flop.
      last_grant_q <= REQ_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/yadmc_dpram_arb.sv
// Arbitrates two requesters onto port 0 of a dpram. Commands are registered
// onto mem_*; reads return two edges after acceptance on the shared rdata.
module yadmc_dpram_arb
  import yadmc_dpram_pkg::*;
#(
  parameter int address_depth = DEFAULT_ADDRESS_DEPTH,
  parameter int data_width    = DEFAULT_DATA_WIDTH
)(
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  yadmc_dpram_arb_if.slave         req,
  output logic [address_depth-1:0] mem_adr,
  output logic                     mem_we,
  output logic [data_width-1:0]    mem_di,
  input  logic [data_width-1:0]    mem_do
);

  logic grant_a;
  logic grant_b;

  logic [address_depth-1:0] mem_adr_q, mem_adr_d;
  logic                     mem_we_q,  mem_we_d;
  logic [data_width-1:0]    mem_di_q,  mem_di_d;
  rd_tag_t                  rd_s1_q,   rd_s1_d;
  rd_tag_t                  rd_s2_q,   rd_s2_d;
  logic                     a_rvalid_q, a_rvalid_d;
  logic                     b_rvalid_q, b_rvalid_d;
  logic [data_width-1:0]    rdata_q,   rdata_d;

  yadmc_rr_arb2 u_arb (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .valid_a (req.a_valid),
    .valid_b (req.b_valid),
    .accept  (grant_a || grant_b),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  always_comb begin
    mem_adr_d = mem_adr_q;
    mem_di_d  = mem_di_q;
    mem_we_d  = 1'b0;
    rd_s1_d   = RD_TAG_IDLE;
    if (grant_b) begin
      mem_adr_d = req.b_adr;
      mem_we_d  = req.b_we;
      mem_di_d  = req.b_di;
      rd_s1_d   = '{valid: !req.b_we, id: REQ_B};
    end else if (grant_a) begin
      mem_adr_d = req.a_adr;
      mem_we_d  = req.a_we;
      mem_di_d  = req.a_di;
      rd_s1_d   = '{valid: !req.a_we, id: REQ_A};
    end

    // Stage 2 lines up with mem_do: the dpram has sampled mem_adr one edge ago.
    rd_s2_d    = rd_s1_q;
    a_rvalid_d = rd_s2_q.valid && rd_s2_q.id == REQ_A;
    b_rvalid_d = rd_s2_q.valid && rd_s2_q.id == REQ_B;
    rdata_d    = rd_s2_q.valid ? mem_do : rdata_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mem_adr_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_di_q   <= '0;
      rd_s1_q    <= RD_TAG_IDLE;
      rd_s2_q    <= RD_TAG_IDLE;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mem_adr_q  <= mem_adr_d;
      mem_we_q   <= mem_we_d;
      mem_di_q   <= mem_di_d;
      rd_s1_q    <= rd_s1_d;
      rd_s2_q    <= rd_s2_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign req.a_ready  = grant_a;
  assign req.b_ready  = grant_b;
  assign req.a_rvalid = a_rvalid_q;
  assign req.b_rvalid = b_rvalid_q;
  assign req.rdata    = rdata_q;

  assign mem_adr = mem_adr_q;
  assign mem_we  = mem_we_q;
  assign mem_di  = mem_di_q;

endmodule
